// File: rtl/out_port_uart_tx.sv
// rtl/out_port_uart_tx.sv - byte FIFO plus 8N1 UART transmitter for the processor output port
//
// Purpose:
//   Buffers bytes written by the OUT instruction and serializes them LSB first
//   as 8N1 frames of exactly 10*CLKS_PER_BIT cycles. Frames are sent back to
//   back with no idle gap whenever the buffer still holds data.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset; aborts any frame and empties the FIFO
//   wr_en      one-cycle write strobe from the output-port stage
//   wr_data    byte to queue, valid with wr_en
//   fifo_full  registered; FIFO holds FIFO_DEPTH bytes (stall request)
//   fifo_count registered number of buffered bytes
//   overflow   sticky; a write was dropped because the FIFO was full
//   tx_busy    registered; transmitter is not idle
//   tx         registered serial output, idles high

module out_port_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_W       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              fifo_full,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic              tx_busy,
    output logic              tx
);

    localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]  DEPTH_C   = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];

    logic accept;
    logic pop;
    logic baud_end;

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mem_d      = mem_q;
        pop        = 1'b0;
        // Full is judged on the registered flag, so a pop at the same edge
        // does not rescue a write into a full buffer.
        accept     = wr_en && !full_q;
        baud_end   = (baud_q == BAUD_LAST);

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = 3'd0;
                    baud_d    = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // shift_q[1] is the bit that becomes shift_d[0]
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (count_q != '0) begin
                        // Chain straight into the next start bit
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);

        if (accept) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d     = (count_d == DEPTH_C);
        overflow_d = overflow_q | (wr_en & full_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign fifo_full  = full_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign tx_busy    = busy_q;
    assign tx         = tx_q;

endmodule

// File: doc/out_port_uart_tx.md
Name: out_port_uart_tx

Overview:
- Downstream consumer of the processor's registered 8-bit output port.
- Accepts one byte per OUT-instruction write strobe and buffers it in a small FIFO.
- Serializes each byte onto a single UART line, 8N1, LSB first, with a fixed clocks-per-bit divider.
- Reports FIFO full so the hazard/stall logic can hold the OUT instruction, and flags any write that was dropped.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 4: byte entries in the buffer; must be a power of 2, minimum 2.
- ADDR_W, 2: FIFO pointer width; must equal log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  one-cycle write strobe from the output-port stage.
- wr_data  in  8  byte to transmit; valid when wr_en=1.
- fifo_full  out  1  registered; 1 when the FIFO holds FIFO_DEPTH bytes; drives the stall request.
- fifo_count  out  ADDR_W+1  registered count of buffered bytes.
- overflow  out  1  sticky flag: a write was dropped because the FIFO was full.
- tx_busy  out  1  registered; 1 whenever the FSM is not IDLE.
- tx  out  1  registered UART serial output; idles high.

Behaviour:
- Reset: clk edge with rst=1 sets:
  - tx=1, state=IDLE, tx_busy=0, baud counter=0, bit index=0;
  - FIFO pointers=0, fifo_count=0, fifo_full=0, overflow=0.
  - rst overrides every other input.
  - Reset mid-frame aborts the frame, drives tx=1 from that edge, and discards all buffered bytes.
- FIFO write:
  - at an edge with wr_en=1 and fifo_full=0, store wr_data at the write pointer and advance the pointer, wrapping modulo FIFO_DEPTH.
  - wr_en=1 while fifo_full=1 drops the byte and sets overflow=1. This holds even if a pop happens at the same edge, because full is judged on the registered count.
  - overflow clears only on rst.
- FIFO pop: done only by the FSM, only when fifo_count>0. The read pointer wraps modulo FIFO_DEPTH.
- Simultaneous accepted write and pop: fifo_count unchanged; data order preserved.
- fifo_full is derived from the next-state count, so it is valid in the cycle after the write that fills the FIFO.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count>0 at an edge: pop head into an 8-bit shift register, tx<=0, baud counter<=0, go to START.
  - START: hold tx=0 for CLKS_PER_BIT cycles. On the last cycle: tx<=shift[0], bit index<=0, go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles. At each bit end, shift right and present the next bit. After bit 7's period: tx<=1, go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. At the end:
    - if fifo_count>0, pop, tx<=0, go straight to START (no idle gap);
    - otherwise go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles; back-to-back frames are contiguous.
- Latency: a byte written at edge E into an empty FIFO with the FSM in IDLE gives a start bit (tx=0) from edge E+1.
- The baud counter runs 0..CLKS_PER_BIT-1 and resets at every bit boundary. Widen it to hold CLKS_PER_BIT-1.
- tx_busy=1 from the edge that leaves IDLE until the edge that returns to IDLE.
- A write arriving while tx_busy=1 only queues; it never disturbs the frame in flight.

Test Plan:
- Reset with CLKS_PER_BIT=4: after rst, tx=1, tx_busy=0, fifo_count=0, overflow=0; hold rst for 3 cycles with wr_en=1 → nothing queued.
- Single byte 0xA5 at edge 0:
  - tx low from edge 1 for 4 cycles;
  - then bits 1,0,1,0,0,1,0,1, each 4 cycles;
  - then stop high for 4 cycles; tx_busy drops at edge 41.
- Back-to-back 0x00 then 0xFF written on consecutive edges:
  - second start bit begins exactly 40 cycles after the first;
  - tx never idles between frames; fifo_count goes 1,1,0.
- Fill: six consecutive writes 0x01..0x06 from idle:
  - fifo_count goes 1,1,2,3,4; fifo_full=1 after edge 4;
  - 0x06 dropped, overflow=1;
  - transmitted sequence is 0x01..0x05 only.
- Simultaneous write/pop at a STOP end with fifo_count=1 → count stays 1; the popped byte is the older one.
- Reset asserted during DATA bit 3 → tx=1 next edge, FIFO empty; a subsequent write of 0x3C transmits correctly.
